id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Decode-stage controller for the 5-stage RV32I pipeline.
- Owns the IF/ID pipeline register and drives IMM_SRC to the immediate generator from the held instruction.
- Detects load-use hazards against the EX stage and sequences stalls and bubbles.
- Flushes on taken branches and jumps resolved in EX; keeps saturating stall and flush performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded into ID_PC_o on reset
NOP_INSTR, 32'h0000_0013, instruction held in IF/ID on reset or flush (addi x0,x0,0)
CNT_W, 16, width of the performance counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
INSTR_i  in  32  instruction from fetch
PC_i  in  32  PC of INSTR_i
FETCH_VALID_i  in  1  INSTR_i/PC_i valid this cycle
EX_MEMREAD_i  in  1  instruction in EX is a load
EX_RD_i  in  5  destination register of the EX instruction
BR_TAKEN_i  in  1  branch/jump taken, resolved in EX
MEM_BUSY_i  in  1  data memory not ready; freezes the front end
ID_INSTR_o  out  32  IF/ID instruction register
ID_PC_o  out  32  IF/ID PC register
ID_VALID_o  out  1  IF/ID valid bit
IMM_SRC_o  out  2  immediate type: 00 I, 01 U, 10 B, 11 J
PC_EN_o  out  1  fetch PC update enable
IDEX_BUBBLE_o  out  1  ID/EX register loads a bubble this cycle
STALL_CNT_o  out  CNT_W  count of load-use stall cycles, saturating
FLUSH_CNT_o  out  CNT_W  count of flush events, saturating

Behaviour:
Reset
- While RST is high at a clock edge: ID_INSTR_o=NOP_INSTR, ID_PC_o=RESET_PC, ID_VALID_o=0, both counters=0.
- PC_EN_o and IDEX_BUBBLE_o are combinational; during reset they evaluate from the reset register values (PC_EN_o=1, IDEX_BUBBLE_o=0 unless BR_TAKEN_i/MEM_BUSY_i asserted).
- Reset mid-stall or mid-flush abandons it; no state survives.

Register-use decode (rs1=ID_INSTR_o[19:15], rs2=[24:20], opcode=[6:0])
- uses_rs1 = all opcodes except 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL).
- uses_rs2 = opcodes 0110011 (R-type), 0100011 (store), 1100011 (branch).

IMM_SRC_o (combinational from ID_INSTR_o)
- 0110111, 0010111 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- All others, including 0000011, 0010011, 1100111 -> 00.

Hazard condition
- load_use = ID_VALID_o & EX_MEMREAD_i & (EX_RD_i!=0) & ((uses_rs1 & EX_RD_i==rs1) | (uses_rs2 & EX_RD_i==rs2)).

Priority per cycle: MEM_BUSY_i > BR_TAKEN_i > load_use > normal.
- MEM_BUSY_i=1: PC_EN_o=0, IDEX_BUBBLE_o=0. IF/ID holds. Counters unchanged. A simultaneous BR_TAKEN_i is ignored; EX holds it until busy drops.
- BR_TAKEN_i=1 (flush): PC_EN_o=1, IDEX_BUBBLE_o=1. Next edge IF/ID <= {NOP_INSTR, PC_i, 0}. FLUSH_CNT_o +1. A simultaneous load_use is discarded and STALL_CNT_o is not incremented.
- load_use=1 (stall): PC_EN_o=0, IDEX_BUBBLE_o=1. IF/ID holds. STALL_CNT_o +1.
  - The stall lasts exactly one cycle: the bubble clears EX_MEMREAD_i, so the condition self-releases.
- Normal: PC_EN_o=1, IDEX_BUBBLE_o=0. Next edge IF/ID <= {INSTR_i, PC_i, FETCH_VALID_i}.
  - FETCH_VALID_i=0 loads NOP_INSTR with ID_VALID_o=0.

Other rules
- Counters saturate at all-ones and do not wrap.
- Latency: INSTR_i appears on ID_INSTR_o one cycle after capture. IMM_SRC_o is valid in the same cycle as ID_INSTR_o.
- An ID_VALID_o=0 slot never causes a stall.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - IMM_SRC encodings: IMM_I=2'b00, IMM_U=2'b01, IMM_B=2'b10, IMM_J=2'b11.
  - NOP constant.
- One sub-module, sat_counter (parameterised width, synchronous reset, increment enable), instantiated twice.
- Decode and hazard logic stay inline.

Test Plan:
- Reset then FETCH_VALID_i=1, INSTR_i=32'h00500093, PC_i=0x0 -> next cycle ID_INSTR_o=0x00500093, ID_VALID_o=1, IMM_SRC_o=00, PC_EN_o=1.
- ID holds add x3,x1,x2 (0x002081B3); EX_MEMREAD_i=1, EX_RD_i=2 -> PC_EN_o=0, IDEX_BUBBLE_o=1 for one cycle. IF/ID unchanged, STALL_CNT_o=1. Release next cycle with EX_MEMREAD_i=0.
- Same hazard but EX_RD_i=0, and separately ID holds LUI x5 (0x000012B7) with EX_RD_i=5 -> no stall, STALL_CNT_o stays 0, LUI gives IMM_SRC_o=01.
- BR_TAKEN_i=1 coincident with load_use -> IDEX_BUBBLE_o=1, PC_EN_o=1. Next cycle ID_INSTR_o=0x00000013, ID_VALID_o=0. FLUSH_CNT_o=1, STALL_CNT_o=0.
- MEM_BUSY_i=1 for 3 cycles with BR_TAKEN_i=1 -> PC_EN_o=0, IF/ID frozen, no flush counted. After busy drops, the flush occurs.
- Force 2^CNT_W+5 stall cycles -> STALL_CNT_o saturates at 16'hFFFF. Assert RST mid-sequence -> counters 0 and ID_VALID_o=0 next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I constants: base opcodes, immediate-type encodings and the canonical NOP.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_U = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage controller: owns IF/ID, decodes IMM_SRC, detects load-use hazards
// against EX and sequences stall/flush/freeze with saturating event counters.
module id_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      INSTR_i,
    input  logic [31:0]      PC_i,
    input  logic             FETCH_VALID_i,
    input  logic             EX_MEMREAD_i,
    input  logic [4:0]       EX_RD_i,
    input  logic             BR_TAKEN_i,
    input  logic             MEM_BUSY_i,
    output logic [31:0]      ID_INSTR_o,
    output logic [31:0]      ID_PC_o,
    output logic             ID_VALID_o,
    output logic [1:0]       IMM_SRC_o,
    output logic             PC_EN_o,
    output logic             IDEX_BUBBLE_o,
    output logic [CNT_W-1:0] STALL_CNT_o,
    output logic [CNT_W-1:0] FLUSH_CNT_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    assign opcode = instr_q[6:0];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];

    assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    always_comb begin
        IMM_SRC_o = IMM_I;
        case (opcode)
            OP_LUI, OP_AUIPC: IMM_SRC_o = IMM_U;
            OP_BRANCH:        IMM_SRC_o = IMM_B;
            OP_JAL:           IMM_SRC_o = IMM_J;
            default:          IMM_SRC_o = IMM_I;
        endcase
    end

    // Stall self-releases: the bubble it inserts clears EX_MEMREAD_i next cycle.
    assign load_use = valid_q && EX_MEMREAD_i && (EX_RD_i != 5'd0) &&
                      ((uses_rs1 && (EX_RD_i == rs1)) || (uses_rs2 && (EX_RD_i == rs2)));

    // Priority: memory busy freezes everything, then flush, then load-use stall.
    always_comb begin
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        PC_EN_o       = 1'b1;
        IDEX_BUBBLE_o = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (MEM_BUSY_i) begin
            PC_EN_o = 1'b0;
        end else if (BR_TAKEN_i) begin
            IDEX_BUBBLE_o = 1'b1;
            flush_inc     = 1'b1;
            instr_d       = NOP_INSTR;
            pc_d          = PC_i;
            valid_d       = 1'b0;
        end else if (load_use) begin
            PC_EN_o       = 1'b0;
            IDEX_BUBBLE_o = 1'b1;
            stall_inc     = 1'b1;
        end else begin
            instr_d = FETCH_VALID_i ? INSTR_i : NOP_INSTR;
            pc_d    = PC_i;
            valid_d = FETCH_VALID_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign ID_INSTR_o = instr_q;
    assign ID_PC_o    = pc_q;
    assign ID_VALID_o = valid_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (stall_inc),
        .count_o (STALL_CNT_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (flush_inc),
        .count_o (FLUSH_CNT_o)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: IF/ID contents checked through an expected queue,
// control outputs and counters checked against bench-side constants.
module tb_id_hazard_ctrl;

    logic        CLK;
    logic        RST;
    logic [31:0] INSTR_i;
    logic [31:0] PC_i;
    logic        FETCH_VALID_i;
    logic        EX_MEMREAD_i;
    logic [4:0]  EX_RD_i;
    logic        BR_TAKEN_i;
    logic        MEM_BUSY_i;
    logic [31:0] ID_INSTR_o;
    logic [31:0] ID_PC_o;
    logic        ID_VALID_o;
    logic [1:0]  IMM_SRC_o;
    logic        PC_EN_o;
    logic        IDEX_BUBBLE_o;
    logic [15:0] STALL_CNT_o;
    logic [15:0] FLUSH_CNT_o;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [31:0] ADD_W = 32'h0020_81B3;
    localparam logic [31:0] LUI_W = 32'h0000_12B7;

    int total = 0;
    int bad   = 0;

    // {instr, pc, valid} expected in IF/ID after the next edge
    logic [64:0] exp_q[$];

    id_hazard_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .INSTR_i       (INSTR_i),
        .PC_i          (PC_i),
        .FETCH_VALID_i (FETCH_VALID_i),
        .EX_MEMREAD_i  (EX_MEMREAD_i),
        .EX_RD_i       (EX_RD_i),
        .BR_TAKEN_i    (BR_TAKEN_i),
        .MEM_BUSY_i    (MEM_BUSY_i),
        .ID_INSTR_o    (ID_INSTR_o),
        .ID_PC_o       (ID_PC_o),
        .ID_VALID_o    (ID_VALID_o),
        .IMM_SRC_o     (IMM_SRC_o),
        .PC_EN_o       (PC_EN_o),
        .IDEX_BUBBLE_o (IDEX_BUBBLE_o),
        .STALL_CNT_o   (STALL_CNT_o),
        .FLUSH_CNT_o   (FLUSH_CNT_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_fetch(input logic [31:0] instr, input logic [31:0] pc, input logic v);
        INSTR_i       = instr;
        PC_i          = pc;
        FETCH_VALID_i = v;
    endtask

    task automatic push_id(input logic [31:0] instr, input logic [31:0] pc, input logic v);
        exp_q.push_back({instr, pc, v});
    endtask

    task automatic check_id(input string tag);
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, ID_INSTR_o, e[64:33]);
            chk({tag, "_pc"}, ID_PC_o, e[32:1]);
            chk({tag, "_valid"}, {31'd0, ID_VALID_o}, {31'd0, e[0]});
        end
    endtask

    logic [31:0] imm_instr [4];
    logic [1:0]  imm_exp   [4];

    initial begin
        RST = 1'b1;
        drive_fetch(32'd0, 32'd0, 1'b0);
        EX_MEMREAD_i = 1'b0;
        EX_RD_i      = 5'd0;
        BR_TAKEN_i   = 1'b0;
        MEM_BUSY_i   = 1'b0;
        imm_instr[0] = 32'h0020_8463; imm_exp[0] = 2'b10;
        imm_instr[1] = 32'h0000_006F; imm_exp[1] = 2'b11;
        imm_instr[2] = 32'h0000_8067; imm_exp[2] = 2'b00;
        imm_instr[3] = 32'h0000_1017; imm_exp[3] = 2'b01;

        // Reset state
        step();
        step();
        chk("rst_instr", ID_INSTR_o, NOP_W);
        chk("rst_pc", ID_PC_o, 32'd0);
        chk("rst_valid", {31'd0, ID_VALID_o}, 32'd0);
        chk("rst_stall_cnt", {16'd0, STALL_CNT_o}, 32'd0);
        chk("rst_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd0);
        chk("rst_pc_en", {31'd0, PC_EN_o}, 32'd1);
        chk("rst_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd0);
        RST = 1'b0;

        // First capture
        drive_fetch(32'h0050_0093, 32'h0, 1'b1);
        push_id(32'h0050_0093, 32'h0, 1'b1);
        #1 chk("cap_pc_en", {31'd0, PC_EN_o}, 32'd1);
        step();
        check_id("cap0");
        chk("cap0_imm", {30'd0, IMM_SRC_o}, 32'd0);

        // Load add x3,x1,x2
        drive_fetch(ADD_W, 32'h4, 1'b1);
        push_id(ADD_W, 32'h4, 1'b1);
        step();
        check_id("add");

        // EX_RD=0 never hazards
        drive_fetch(32'h1111_1111, 32'h8, 1'b1);
        EX_MEMREAD_i = 1'b1;
        EX_RD_i      = 5'd0;
        #1;
        chk("rd0_pc_en", {31'd0, PC_EN_o}, 32'd1);
        chk("rd0_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd0);

        // Real load-use on rs2
        EX_RD_i = 5'd2;
        #1;
        chk("lu_pc_en", {31'd0, PC_EN_o}, 32'd0);
        chk("lu_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd1);
        push_id(ADD_W, 32'h4, 1'b1);
        step();
        check_id("lu_hold");
        chk("lu_stall_cnt", {16'd0, STALL_CNT_o}, 32'd1);

        // Release, fetch LUI
        EX_MEMREAD_i = 1'b0;
        drive_fetch(LUI_W, 32'h8, 1'b1);
        push_id(LUI_W, 32'h8, 1'b1);
        #1 chk("rel_pc_en", {31'd0, PC_EN_o}, 32'd1);
        step();
        check_id("lui");
        chk("lui_imm", {30'd0, IMM_SRC_o}, 32'd1);

        // LUI does not read rs1/rs2
        EX_MEMREAD_i = 1'b1;
        EX_RD_i      = 5'd5;
        drive_fetch(ADD_W, 32'h10, 1'b1);
        push_id(ADD_W, 32'h10, 1'b1);
        #1;
        chk("lui_pc_en", {31'd0, PC_EN_o}, 32'd1);
        chk("lui_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd0);
        step();
        check_id("add2");
        chk("lui_stall_cnt", {16'd0, STALL_CNT_o}, 32'd1);

        // Flush coincident with load-use on rs1
        EX_RD_i    = 5'd1;
        BR_TAKEN_i = 1'b1;
        drive_fetch(32'h2222_2222, 32'h20, 1'b1);
        push_id(NOP_W, 32'h20, 1'b0);
        #1;
        chk("fl_pc_en", {31'd0, PC_EN_o}, 32'd1);
        chk("fl_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd1);
        step();
        check_id("flush");
        chk("fl_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd1);
        chk("fl_stall_cnt", {16'd0, STALL_CNT_o}, 32'd1);
        BR_TAKEN_i   = 1'b0;
        EX_MEMREAD_i = 1'b0;

        // Busy freeze with pending branch
        drive_fetch(32'h00A0_0113, 32'h24, 1'b1);
        push_id(32'h00A0_0113, 32'h24, 1'b1);
        step();
        check_id("pre_busy");
        MEM_BUSY_i = 1'b1;
        BR_TAKEN_i = 1'b1;
        drive_fetch(32'hDEAD_BEEF, 32'h28, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_pc_en", {31'd0, PC_EN_o}, 32'd0);
            chk("busy_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd0);
            push_id(32'h00A0_0113, 32'h24, 1'b1);
            step();
            check_id("busy_hold");
            chk("busy_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd1);
        end
        MEM_BUSY_i = 1'b0;
        push_id(NOP_W, 32'h28, 1'b0);
        #1;
        chk("unbusy_bubble", {31'd0, IDEX_BUBBLE_o}, 32'd1);
        chk("unbusy_pc_en", {31'd0, PC_EN_o}, 32'd1);
        step();
        check_id("unbusy_flush");
        chk("unbusy_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd2);
        BR_TAKEN_i = 1'b0;

        // Invalid fetch loads a NOP
        drive_fetch(32'h1234_5678, 32'h2C, 1'b0);
        push_id(NOP_W, 32'h2C, 1'b0);
        step();
        check_id("invalid");

        // Immediate-type table
        for (int i = 0; i < 4; i++) begin
            drive_fetch(imm_instr[i], 32'h30 + 32'(i * 4), 1'b1);
            push_id(imm_instr[i], 32'h30 + 32'(i * 4), 1'b1);
            step();
            check_id("imm_tbl");
            chk("imm_tbl_src", {30'd0, IMM_SRC_o}, {30'd0, imm_exp[i]});
        end

        // Continuous stalls to saturation
        drive_fetch(ADD_W, 32'h40, 1'b1);
        push_id(ADD_W, 32'h40, 1'b1);
        step();
        check_id("sat_pre");
        EX_MEMREAD_i = 1'b1;
        EX_RD_i      = 5'd2;
        drive_fetch(32'h3333_3333, 32'h44, 1'b1);
        repeat (65536 + 5) step();
        chk("sat_stall_cnt", {16'd0, STALL_CNT_o}, 32'h0000_FFFF);
        chk("sat_pc_en", {31'd0, PC_EN_o}, 32'd0);
        chk("sat_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd2);

        // Reset mid-stall
        RST = 1'b1;
        step();
        chk("mid_rst_stall_cnt", {16'd0, STALL_CNT_o}, 32'd0);
        chk("mid_rst_flush_cnt", {16'd0, FLUSH_CNT_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, ID_VALID_o}, 32'd0);
        chk("mid_rst_instr", ID_INSTR_o, NOP_W);
        chk("mid_rst_pc_en", {31'd0, PC_EN_o}, 32'd1);
        RST          = 1'b0;
        EX_MEMREAD_i = 1'b0;

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_queue observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
